ipr_mem_arbiter: RTL and testbench

IPR_MEM_ARBITER -- requirements
Module: ipr_mem_arbiter

---
 rtl/ipr_pkg.sv | 23 ++
 rtl/ipr_mem_arbiter_if.sv | 17 +
 rtl/ipr_id_fifo.sv | 56 +++++
 rtl/ipr_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_ipr_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ipr_pkg.sv
// Shared types and bus widths for the two-master memory arbiter.
package ipr_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic {
    SRC_RD = 1'b0,
    SRC_WR = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK_RD = 2'd1,
    LOCK_WR = 2'd2
  } arb_state_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_RD) ? SRC_WR : SRC_RD;
  endfunction

endpackage

// File: rtl/ipr_mem_arbiter_if.sv
// Request/response memory bus; a master issues requests, a slave grants and responds.
interface ipr_mem_arbiter_if;
  import ipr_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic [BE_W-1:0]   be;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, wdata, we, be, input gnt, rvalid, rdata);
  modport slave  (input req, addr, wdata, we, be, output gnt, rvalid, rdata);

endinterface

// File: rtl/ipr_id_fifo.sv
// In-order FIFO of 1-bit source IDs, one entry per outstanding memory transaction.
module ipr_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] store;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign dout    = store[rptr];

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
    end else begin
      if (do_push) begin
        store[wptr] <= din;
        wptr        <= (wptr == LAST_PTR) ? '0 : wptr + PW'(1);
      end
      if (do_pop) begin
        rptr <= (rptr == LAST_PTR) ? '0 : rptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ipr_mem_arbiter.sv
// Round-robin arbiter sharing one pipelined memory slave between a read and a write master.
module ipr_mem_arbiter
  import ipr_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ipr_mem_arbiter_if.slave     rd,
  ipr_mem_arbiter_if.slave     wr,
  ipr_mem_arbiter_if.master    mem,
  output logic                 unexp_rvalid
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

  arb_state_e    state;
  arb_state_e    state_nxt;
  src_e          last_src;
  src_e          sel;
  src_e          head_src;
  logic [CW-1:0] count;
  logic          sel_req;
  logic          room;
  logic          req_int;
  logic          hs;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          head_bit;
  logic          unused_rd_wdata;

  assign unused_rd_wdata = ^rd.wdata;
  assign head_src        = src_e'(head_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A stalled request pins its source until the slave finally accepts it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_int && !mem.gnt) begin
          state_nxt = (sel == SRC_WR) ? LOCK_WR : LOCK_RD;
        end
      end
      LOCK_RD, LOCK_WR: begin
        if (hs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is forced low while reset is held, including the data paths.
  always_comb begin
    sel = SRC_RD;
    unique case (state)
      LOCK_RD: sel = SRC_RD;
      LOCK_WR: sel = SRC_WR;
      IDLE: begin
        if (rd.req && wr.req) begin
          sel = other_src(last_src);
        end else if (wr.req) begin
          sel = SRC_WR;
        end else begin
          sel = SRC_RD;
        end
      end
      default: sel = SRC_RD;
    endcase

    sel_req = (sel == SRC_WR) ? wr.req : rd.req;
    room    = (count < MAX_C) && !fifo_full;
    req_int = rst_n && sel_req && room;
    hs      = req_int && mem.gnt;
    pop     = rst_n && mem.rvalid && !fifo_empty;

    mem.req   = req_int;
    mem.addr  = '0;
    mem.we    = 1'b0;
    mem.be    = '0;
    mem.wdata = '0;
    if (rst_n) begin
      mem.addr  = (sel == SRC_WR) ? wr.addr : rd.addr;
      mem.we    = (sel == SRC_WR) ? wr.we : rd.we;
      mem.be    = (sel == SRC_WR) ? wr.be : rd.be;
      mem.wdata = (sel == SRC_WR) ? wr.wdata : '0;
    end

    rd.gnt       = hs && (sel == SRC_RD);
    wr.gnt       = hs && (sel == SRC_WR);
    rd.rvalid    = pop && (head_src == SRC_RD);
    wr.rvalid    = pop && (head_src == SRC_WR);
    rd.rdata     = rst_n ? mem.rdata : '0;
    wr.rdata     = rst_n ? mem.rdata : '0;
    unexp_rvalid = rst_n && mem.rvalid && fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_src <= SRC_WR;
      count    <= '0;
    end else begin
      if (hs) begin
        last_src <= sel;
      end
      case ({hs, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  ipr_id_fifo #(
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (hs),
    .din   (sel),
    .pop   (pop),
    .dout  (head_bit),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_ipr_mem_arbiter.sv
// Bench for ipr_mem_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_ipr_mem_arbiter;
  import ipr_pkg::*;

  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rstVal;
  logic unexp;

  ipr_mem_arbiter_if rd_bus ();
  ipr_mem_arbiter_if wr_bus ();
  ipr_mem_arbiter_if mem_bus ();

  ipr_mem_arbiter #(
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd           (rd_bus),
    .wr           (wr_bus),
    .mem          (mem_bus),
    .unexp_rvalid (unexp)
  );

  always #5 clk = ~clk;

  int compares = 0;
  int errors   = 0;

  bit mq[$];
  bit lastWr;
  bit pendValid;
  bit pendWr;
  bit evalValid;
  bit selWr;
  bit expMemReq, expHs, expRdGnt, expWrGnt, expRdRv, expWrRv, expUnexp, popAvail;
  logic [31:0] expAddr, expWdata, expRdata;
  logic        expWe;
  logic [3:0]  expBe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rq, input bit wq, input bit g, input bit rv,
                               input logic [31:0] rdat);
    rd_bus.req    = rq;
    rd_bus.addr   = $urandom;
    rd_bus.we     = 1'($urandom);
    rd_bus.be     = 4'($urandom);
    rd_bus.wdata  = $urandom;
    wr_bus.req    = wq;
    wr_bus.addr   = $urandom;
    wr_bus.we     = 1'($urandom);
    wr_bus.be     = 4'($urandom);
    wr_bus.wdata  = $urandom;
    mem_bus.gnt    = g;
    mem_bus.rvalid = rv;
    mem_bus.rdata  = rdat;
  endtask

  // Reference: a queue of outstanding source IDs, the last winner, and a pinned source.
  task automatic modelEval();
    expMemReq = 0; expHs = 0; expRdGnt = 0; expWrGnt = 0;
    expRdRv = 0; expWrRv = 0; expUnexp = 0; popAvail = 0;
    expAddr = '0; expWdata = '0; expWe = 0; expBe = '0; expRdata = '0;
    if (!rst_n) begin
      mq.delete();
      lastWr    = 1;
      pendValid = 0;
      return;
    end
    if (pendValid)                  selWr = pendWr;
    else if (rd_bus.req && wr_bus.req) selWr = !lastWr;
    else                            selWr = wr_bus.req;
    expMemReq = (selWr ? wr_bus.req : rd_bus.req) && (mq.size() < MAX_OUT);
    expHs     = expMemReq && mem_bus.gnt;
    expRdGnt  = expHs && !selWr;
    expWrGnt  = expHs && selWr;
    if (mem_bus.rvalid) begin
      if (mq.size() > 0) begin
        popAvail = 1;
        expRdRv  = (mq[0] == 0);
        expWrRv  = (mq[0] == 1);
      end else begin
        expUnexp = 1;
      end
    end
    expAddr  = selWr ? wr_bus.addr : rd_bus.addr;
    expWe    = selWr ? wr_bus.we : rd_bus.we;
    expBe    = selWr ? wr_bus.be : rd_bus.be;
    expWdata = selWr ? wr_bus.wdata : 32'h0;
    expRdata = mem_bus.rdata;
  endtask

  task automatic modelAdvance();
    if (!rst_n) return;
    if (popAvail) void'(mq.pop_front());
    if (expHs) begin
      mq.push_back(selWr);
      lastWr    = selWr;
      pendValid = 0;
    end else if (expMemReq && !mem_bus.gnt) begin
      pendValid = 1;
      pendWr    = selWr;
    end
  endtask

  task automatic checkOutput();
    check("mem_req", 32'(mem_bus.req), 32'(expMemReq));
    check("rd_gnt", 32'(rd_bus.gnt), 32'(expRdGnt));
    check("wr_gnt", 32'(wr_bus.gnt), 32'(expWrGnt));
    check("rd_rvalid", 32'(rd_bus.rvalid), 32'(expRdRv));
    check("wr_rvalid", 32'(wr_bus.rvalid), 32'(expWrRv));
    check("unexp_rvalid", 32'(unexp), 32'(expUnexp));
    check("rd_rdata", rd_bus.rdata, expRdata);
    check("wr_rdata", wr_bus.rdata, expRdata);
    if (expMemReq) begin
      check("mem_addr", mem_bus.addr, expAddr);
      check("mem_we", 32'(mem_bus.we), 32'(expWe));
      check("mem_be", 32'(mem_bus.be), 32'(expBe));
      check("mem_wdata", mem_bus.wdata, expWdata);
    end
    if (!rst_n) begin
      check("reset mem_addr", mem_bus.addr, 32'h0);
    end
  endtask

  task automatic step(input bit rq, input bit wq, input bit g, input bit rv,
                      input logic [31:0] rdat);
    @(posedge clk);
    if (evalValid) modelAdvance();
    @(negedge clk);
    rst_n = rstVal;
    applyStimulus(rq, wq, g, rv, rdat);
    #1;
    modelEval();
    evalValid = 1;
    checkOutput();
  endtask

  task automatic doReset();
    rstVal = 0;
    step(1, 1, 1, 1, 32'h0);
    check("reset mem_req literal", 32'(mem_bus.req), 32'h0);
    step(1, 1, 1, 1, 32'h0);
    rstVal = 1;
  endtask

  initial begin
    rst_n = 0;
    rstVal = 0;
    evalValid = 0;
    lastWr = 1;
    pendValid = 0;
    applyStimulus(0, 0, 0, 0, 32'h0);
    doReset();

    // Single read with next-cycle response
    step(1, 0, 1, 0, 32'h0);
    check("r34 rd_gnt", 32'(rd_bus.gnt), 32'h1);
    step(0, 0, 0, 1, 32'hDEADBEEF);
    check("r34 rd_rvalid", 32'(rd_bus.rvalid), 32'h1);
    check("r34 rd_rdata", rd_bus.rdata, 32'hDEADBEEF);
    check("r34 wr_rvalid", 32'(wr_bus.rvalid), 32'h0);

    // Both requesting: alternate starting with RD
    doReset();
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1, 1, 32'h0);
      check("r35 rd_gnt", 32'(rd_bus.gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
      check("r35 wr_gnt", 32'(wr_bus.gnt), (i % 2 == 0) ? 32'h0 : 32'h1);
    end

    // Stalled WR stays pinned while RD arrives
    doReset();
    step(0, 1, 0, 0, 32'h0);
    check("r36 mem_req", 32'(mem_bus.req), 32'h1);
    step(1, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    check("r36 rd_gnt stall", 32'(rd_bus.gnt), 32'h0);
    step(1, 1, 1, 0, 32'h0);
    check("r36 wr_gnt", 32'(wr_bus.gnt), 32'h1);
    check("r36 rd_gnt", 32'(rd_bus.gnt), 32'h0);
    step(1, 1, 1, 0, 32'h0);
    check("r36 rd_gnt next", 32'(rd_bus.gnt), 32'h1);

    // Outstanding limit with no bypass
    doReset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0, 32'h0);
      check("r37 grant", 32'(rd_bus.gnt), 32'h1);
    end
    step(1, 0, 1, 0, 32'h0);
    check("r37 full mem_req", 32'(mem_bus.req), 32'h0);
    step(1, 0, 1, 1, 32'h5A5A5A5A);
    check("r37 no bypass", 32'(mem_bus.req), 32'h0);
    check("r37 rvalid", 32'(rd_bus.rvalid), 32'h1);
    step(1, 0, 1, 0, 32'h0);
    check("r37 resume", 32'(mem_bus.req), 32'h1);

    // Response routing in grant order, then an unexpected response
    doReset();
    step(1, 0, 1, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0);
    step(1, 0, 1, 0, 32'h0);
    step(0, 0, 0, 1, 32'h11111111);
    check("r38 rv0 rd", 32'(rd_bus.rvalid), 32'h1);
    step(0, 0, 0, 1, 32'h22222222);
    check("r38 rv1 wr", 32'(wr_bus.rvalid), 32'h1);
    check("r38 rv1 rd", 32'(rd_bus.rvalid), 32'h0);
    step(0, 0, 0, 1, 32'h33333333);
    check("r38 rv2 rd", 32'(rd_bus.rvalid), 32'h1);
    step(0, 0, 0, 1, 32'h44444444);
    check("r38 unexp", 32'(unexp), 32'h1);
    check("r38 unexp rd_rvalid", 32'(rd_bus.rvalid), 32'h0);
    step(0, 0, 0, 0, 32'h0);
    check("r38 unexp pulse", 32'(unexp), 32'h0);

    // Response to a transaction issued before a mid-run reset
    doReset();
    step(1, 0, 1, 0, 32'h0);
    doReset();
    step(0, 0, 0, 1, 32'h00001234);
    check("post-reset unexp", 32'(unexp), 32'h1);
    check("post-reset rd_rvalid", 32'(rd_bus.rvalid), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", compares, errors);
    $finish;
  end

endmodule
